// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for the shift sequencer, plus the
// side-channel that drives the shared combinational barrel shifter.
interface shift_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 6
);
  // Request channel
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [2:0]       in_op;

  // Result channel
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  // Shared barrel shifter connection
  logic [WIDTH-1:0] bs_in;
  logic [AMT_W-1:0] bs_shift;
  logic [1:0]       bs_sel;
  logic [WIDTH-1:0] bs_out;

  // Requester / result consumer / shifter side
  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready, bs_out,
    input  in_ready, out_valid, out_data, out_err, bs_in, bs_shift, bs_sel
  );

  // Sequencer side
  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready, bs_out,
    output in_ready, out_valid, out_data, out_err, bs_in, bs_shift, bs_sel
  );
endinterface

// File: rtl/shift_sequencer.sv
// Issue/sequencing stage in front of a combinational barrel shifter.
// Single-pass ops (SLL/SRL/SRA) use the shifter once; rotates by a nonzero
// amount use it twice and OR the two partial results. The result is held
// until the consumer takes it; a new request may be accepted in the same
// cycle the held result retires.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus
);

  localparam int LOG_W = AMT_W - 1;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  localparam logic [1:0] SEL_SLL = 2'b00;
  localparam logic [1:0] SEL_SRL = 2'b01;
  localparam logic [1:0] SEL_SRA = 2'b10;

  localparam logic [AMT_W-1:0] AMT_WIDTH = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] AMT_MAX   = AMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [2:0]       op_reg;
  logic [AMT_W-1:0] amt_reg;
  logic [WIDTH-1:0] opnd_reg;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic             err_reg, err_next;
  logic [WIDTH-1:0] bs_in_reg, bs_in_next;
  logic [AMT_W-1:0] bs_shift_reg, bs_shift_next;
  logic [1:0]       bs_sel_reg, bs_sel_next;

  logic             accept;
  logic             amt_big;
  logic [LOG_W-1:0] rot_n;
  logic [AMT_W-1:0] rot_n_ext;
  logic [AMT_W-1:0] rot_back;

  // Rotate amount is taken modulo WIDTH; the second pass shifts the other way
  // by the complement so the two partial results never overlap.
  assign rot_n     = amt_reg[LOG_W-1:0];
  assign rot_n_ext = {1'b0, rot_n};
  assign rot_back  = AMT_WIDTH - rot_n_ext;
  assign amt_big   = (amt_reg >= AMT_WIDTH);

  assign bus.in_ready  = !rst && ((state_reg == IDLE) ||
                                  ((state_reg == HOLD) && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = !rst && (state_reg == HOLD);
  assign bus.out_data  = acc_reg;
  assign bus.out_err   = err_reg;

  // The shifter is combinational, so its controls come straight from the
  // next-state logic; the registered copies only keep them steady elsewhere.
  assign bus.bs_in    = bs_in_next;
  assign bus.bs_shift = bs_shift_next;
  assign bus.bs_sel   = bs_sel_next;

  // State, request and accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      amt_reg      <= '0;
      opnd_reg     <= '0;
      acc_reg      <= '0;
      err_reg      <= 1'b0;
      bs_in_reg    <= '0;
      bs_shift_reg <= '0;
      bs_sel_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      err_reg      <= err_next;
      bs_in_reg    <= bs_in_next;
      bs_shift_reg <= bs_shift_next;
      bs_sel_reg   <= bs_sel_next;
      if (accept) begin
        op_reg   <= bus.in_op;
        amt_reg  <= bus.in_amt;
        opnd_reg <= bus.in_data;
      end
    end
  end

  // Next-state, accumulator update and shifter control
  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    err_next      = err_reg;
    bs_in_next    = bs_in_reg;
    bs_shift_next = bs_shift_reg;
    bs_sel_next   = bs_sel_reg;

    unique case (state_reg)
      IDLE: begin
        if (accept) state_next = P1;
      end

      P1: begin
        bs_in_next = opnd_reg;
        err_next   = 1'b0;
        state_next = HOLD;
        unique case (op_reg)
          OP_SLL, OP_SRL: begin
            bs_sel_next   = (op_reg == OP_SLL) ? SEL_SLL : SEL_SRL;
            bs_shift_next = amt_reg;
            // Logical shifts by WIDTH or more empty the word entirely
            acc_next      = amt_big ? '0 : bus.bs_out;
          end
          OP_SRA: begin
            bs_sel_next   = SEL_SRA;
            bs_shift_next = amt_big ? AMT_MAX : amt_reg;
            acc_next      = bus.bs_out;
          end
          OP_ROL, OP_ROR: begin
            bs_sel_next   = (op_reg == OP_ROL) ? SEL_SLL : SEL_SRL;
            bs_shift_next = rot_n_ext;
            if (rot_n == '0) begin
              acc_next = opnd_reg;
            end else begin
              acc_next   = bus.bs_out;
              state_next = P2;
            end
          end
          default: begin
            bs_sel_next   = SEL_SLL;
            bs_shift_next = '0;
            acc_next      = '0;
            err_next      = 1'b1;
          end
        endcase
      end

      P2: begin
        bs_in_next    = opnd_reg;
        bs_sel_next   = (op_reg == OP_ROL) ? SEL_SRL : SEL_SLL;
        bs_shift_next = rot_back;
        acc_next      = acc_reg | bus.bs_out;
        state_next    = HOLD;
      end

      HOLD: begin
        if (bus.out_ready) state_next = accept ? P1 : IDLE;
      end

      default: state_next = IDLE;
    endcase

    if (rst) begin
      bs_in_next    = '0;
      bs_shift_next = '0;
      bs_sel_next   = '0;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a behavioural barrel shifter.
module tb_shift_sequencer;

  localparam int WIDTH = 32;
  localparam int AMT_W = 6;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  res_t exp_q[$];
  res_t obs_q[$];
  int   acc_q[$];

  shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural barrel shifter: 00 SLL, 01 SRL, 10 SRA
  always_comb begin
    case (bus.bs_sel)
      2'b00:   bus.bs_out = bus.bs_in << bus.bs_shift;
      2'b01:   bus.bs_out = bus.bs_in >> bus.bs_shift;
      2'b10:   bus.bs_out = $unsigned($signed(bus.bs_in) >>> bus.bs_shift);
      default: bus.bs_out = '0;
    endcase
  end

  // Monitor: log accepts and retirements seen ahead of the next edge
  always @(negedge clk) begin
    res_t o;
    if (rst) begin
      acc_q.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
      if (bus.out_valid && bus.out_ready) begin
        o.data = bus.out_data;
        o.err  = bus.out_err;
        o.lat  = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : -1;
        obs_q.push_back(o);
      end
    end
  end

  function automatic void model(input logic [31:0] d, input logic [5:0] a,
                                input logic [2:0] op, output res_t r);
    int n;
    n = a % 32;
    r.err = 1'b0;
    r.lat = 2;
    case (op)
      3'd0: r.data = d << a;
      3'd1: r.data = d >> a;
      3'd2: r.data = $unsigned($signed(d) >>> a);
      3'd3: r.data = (n == 0) ? d : ((d << n) | (d >> (32 - n)));
      3'd4: r.data = (n == 0) ? d : ((d >> n) | (d << (32 - n)));
      default: begin r.data = 32'h0; r.err = 1'b1; end
    endcase
    if ((op == 3'd3 || op == 3'd4) && n != 0) r.lat = 3;
  endfunction

  // Offer one request, wait for it to be taken, record its expectation
  task automatic push_req(input logic [31:0] d, input logic [5:0] a, input logic [2:0] op,
                          input logic [31:0] ed, input logic ee, input int el, input bit keep);
    res_t e;
    bit   took;
    e.data = ed; e.err = ee; e.lat = el;
    if (keep) exp_q.push_back(e);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_amt = a; bus.in_op = op;
    took = 1'b0;
    for (int i = 0; i < 100 && !took; i++) begin
      @(negedge clk);
      if (bus.in_ready) took = 1'b1;
    end
    if (!took) begin
      total++; bad++;
      $display("FAIL accept_timeout op=%0d got=no_ready want=ready", op);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    bus.in_amt   = 6'($urandom);
    bus.in_op    = 3'($urandom);
  endtask

  // Bounded wait for the next observed result
  task automatic get_obs(output res_t o, output bit ok);
    ok = 1'b0;
    o.data = 'x; o.err = 1'bx; o.lat = -1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        ok = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 32'hDEAD_BEEF; bus.in_amt = 6'd3; bus.in_op = 3'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 4;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    if (bus.out_data !== 32'h0 || bus.out_err !== 1'b0) begin
      bad++; $display("FAIL reset_out got=%h/%b want=0/0", bus.out_data, bus.out_err);
    end
    if (bus.bs_in !== 32'h0 || bus.bs_shift !== 6'h0 || bus.bs_sel !== 2'h0) begin
      bad++; $display("FAIL reset_bs got=%h/%h/%h want=0/0/0", bus.bs_in, bus.bs_shift, bus.bs_sel);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", bus.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_pass();
    res_t e, o;
    bit   ok;
    bus.out_ready = 1'b1;
    push_req(32'h0000_000A, 6'd2,  3'd0, 32'h0000_0028, 1'b0, 2, 1'b1);
    push_req(32'h8000_000F, 6'd4,  3'd2, 32'hF800_0000, 1'b0, 2, 1'b1);
    push_req(32'h8000_0000, 6'd40, 3'd2, 32'hFFFF_FFFF, 1'b0, 2, 1'b1);
    push_req(32'hFFFF_FFFF, 6'd40, 3'd1, 32'h0000_0000, 1'b0, 2, 1'b1);
    push_req(32'h1234_5678, 6'd32, 3'd0, 32'h0000_0000, 1'b0, 2, 1'b1);
    push_req(32'h7000_0000, 6'd63, 3'd2, 32'h0000_0000, 1'b0, 2, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL single_timeout got=none want=%h", e.data); end
      else begin
        total += 2;
        if (o.data !== e.data || o.err !== e.err) begin
          bad++; $display("FAIL single_data got=%h/%b want=%h/%b", o.data, o.err, e.data, e.err);
        end
        if (o.lat !== e.lat) begin bad++; $display("FAIL single_latency got=%0d want=%0d", o.lat, e.lat); end
      end
    end
  endtask

  task automatic test_rotate();
    res_t e, o;
    bit   ok;
    bus.out_ready = 1'b1;
    push_req(32'h0000_000F, 6'd4,  3'd4, 32'hF000_0000, 1'b0, 3, 1'b1);
    push_req(32'h8000_0001, 6'd1,  3'd3, 32'h0000_0003, 1'b0, 3, 1'b1);
    push_req(32'hCAFE_F00D, 6'd32, 3'd3, 32'hCAFE_F00D, 1'b0, 2, 1'b1);
    push_req(32'h1234_5678, 6'd0,  3'd4, 32'h1234_5678, 1'b0, 2, 1'b1);
    push_req(32'h1234_5678, 6'd36, 3'd4, 32'h8123_4567, 1'b0, 3, 1'b1);
    push_req(32'h8000_0000, 6'd31, 3'd3, 32'h4000_0000, 1'b0, 3, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rotate_timeout got=none want=%h", e.data); end
      else begin
        total += 2;
        if (o.data !== e.data || o.err !== e.err) begin
          bad++; $display("FAIL rotate_data got=%h/%b want=%h/%b", o.data, o.err, e.data, e.err);
        end
        if (o.lat !== e.lat) begin bad++; $display("FAIL rotate_latency got=%0d want=%0d", o.lat, e.lat); end
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t e, o;
    bit   ok;
    bus.out_ready = 1'b0;
    push_req(32'h0000_0001, 6'd3, 3'd0, 32'h0000_0008, 1'b0, -1, 1'b1);
    e.data = 32'h0012_3456; e.err = 1'b0; e.lat = 2;
    exp_q.push_back(e);
    bus.in_valid = 1'b1; bus.in_data = 32'h1234_5678; bus.in_amt = 6'd8; bus.in_op = 3'd1;
    @(posedge clk); #1;
    repeat (5) begin
      @(negedge clk);
      total += 3;
      if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", bus.out_valid); end
      if (bus.out_data !== 32'h0000_0008 || bus.out_err !== 1'b0) begin
        bad++; $display("FAIL stall_data got=%h/%b want=00000008/0", bus.out_data, bus.out_err);
      end
      if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", bus.in_ready); end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_same_cycle got=%b/%b want=1/1", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL b2b_timeout got=none want=%h", e.data); end
      else begin
        total++;
        if (o.data !== e.data || o.err !== e.err) begin
          bad++; $display("FAIL b2b_data got=%h/%b want=%h/%b", o.data, o.err, e.data, e.err);
        end
        if (e.lat >= 0) begin
          total++;
          if (o.lat !== e.lat) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", o.lat, e.lat); end
        end
      end
    end
  endtask

  task automatic test_illegal();
    res_t e, o;
    bit   ok;
    bus.out_ready = 1'b1;
    push_req(32'hFFFF_FFFF, 6'd5, 3'b110, 32'h0000_0000, 1'b1, 2, 1'b1);
    push_req(32'h0000_00F0, 6'd4, 3'b001, 32'h0000_000F, 1'b0, 2, 1'b1);
    push_req(32'h1111_1111, 6'd1, 3'b101, 32'h0000_0000, 1'b1, 2, 1'b1);
    push_req(32'h0000_0001, 6'd1, 3'b111, 32'h0000_0000, 1'b1, 2, 1'b1);
    push_req(32'h0000_0003, 6'd1, 3'b011, 32'h0000_0006, 1'b0, 3, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL illegal_timeout got=none want=%h", e.data); end
      else begin
        total += 2;
        if (o.data !== e.data) begin bad++; $display("FAIL illegal_data got=%h want=%h", o.data, e.data); end
        if (o.err !== e.err) begin bad++; $display("FAIL illegal_err got=%b want=%b", o.err, e.err); end
      end
    end
  endtask

  task automatic test_reset_mid_rotate();
    res_t e, o;
    bit   ok;
    bus.out_ready = 1'b1;
    push_req(32'h0000_000F, 6'd4, 3'd4, 32'hF000_0000, 1'b0, 3, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_p2_valid got=%b want=0", bus.out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total += 2;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_p2_ready got=%b want=1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_p2_idle_valid got=%b want=0", bus.out_valid); end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (obs_q.size() !== 0) begin bad++; $display("FAIL rst_p2_dropped got=%0d want=0", obs_q.size()); end
    push_req(32'h0000_0005, 6'd4, 3'd0, 32'h0000_0050, 1'b0, 2, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rst_fresh_timeout got=none want=%h", e.data); end
      else begin
        total += 2;
        if (o.data !== e.data || o.err !== e.err) begin
          bad++; $display("FAIL rst_fresh_data got=%h/%b want=%h/%b", o.data, o.err, e.data, e.err);
        end
        if (o.lat !== e.lat) begin bad++; $display("FAIL rst_fresh_latency got=%0d want=%0d", o.lat, e.lat); end
      end
    end
  endtask

  task automatic test_random();
    res_t e, o, r;
    bit   ok;
    logic [31:0] d;
    logic [5:0]  a;
    logic [2:0]  op;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      d  = $urandom;
      a  = 6'($urandom_range(0, 63));
      op = 3'($urandom_range(0, 7));
      model(d, a, op, r);
      push_req(d, a, op, r.data, r.err, r.lat, 1'b1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL random_timeout got=none want=%h", e.data); end
      else begin
        total += 2;
        if (o.data !== e.data || o.err !== e.err) begin
          bad++; $display("FAIL random_data got=%h/%b want=%h/%b", o.data, o.err, e.data, e.err);
        end
        if (o.lat !== e.lat) begin bad++; $display("FAIL random_latency got=%0d want=%0d", o.lat, e.lat); end
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_pass();
    test_rotate();
    test_back_to_back();
    test_illegal();
    test_reset_mid_rotate();
    test_random();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
